mc_control_unit_p: RTL
======================

MC_CONTROL_UNIT_P -- requirements
Module: mc_control_unit_p

Interface
REQ-001 SHALL have parameter OP_W, default 6: opcode width; the opcode map is defined in the low 6 bits, and any higher bits SHALL be zero for a legal opcode.
REQ-002 SHALL have parameter CNT_W, default 16: retired-instruction counter width.
REQ-003 SHALL have parameter WAIT_MAX, default 7: maximum memory wait cycles before a bus error.
REQ-004 SHALL have one clock and an asynchronous active-low reset; ports CLK and Reset, polarity and synchronicity fixed.
REQ-005 Ports, one per line as name  direction  width  meaning:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- opcode  in  OP_W  instruction opcode, held stable by IR from ID onward.
- zero, sign  in  1 each  ALU flags.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel, RD, WR  out  1 each  datapath controls; RD and WR are active-low.
- PCSrc  out  2  00 = PC+4, 01 = branch, 10 = jr, 11 = j/jal.
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd.
- ALUOp  out  3  ALU function code.
- state  out  4  current state.
- halted, illegal, bus_err  out  1 each  sticky status flags.
- instr_count  out  CNT_W  retired-instruction count.

Function
REQ-006 States SHALL use unique encodings: IF=0, ID=1, EAL=2, EBR=3, ELS=4, MLD=5, MST=6, WAL=7, WLD=8, HALT=9; any other encoding SHALL go to IF next cycle.
REQ-007 Opcode map (6 bits): add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, slti 100111, sw 110000, lw 110001, beq 110100, bne 110101, bgtz 110110, j 111000, jr 111001, jal 111010, halt 111111.
REQ-008 Any other opcode SHALL be illegal.
REQ-009 IF SHALL hold while imem_ready=0, and go to ID when imem_ready=1; IRWre=1 and InsMemRW=1 only in the IF cycle in which imem_ready=1.
REQ-010 ID transitions:
- j/jal/jr -> IF.
- halt -> HALT.
- illegal opcode -> HALT, setting illegal.
- ALU ops -> EAL.
- branches -> EBR.
- sw/lw -> ELS.
REQ-011 Remaining transitions:
- EAL -> WAL; WAL -> IF.
- EBR -> IF.
- ELS -> MLD if lw, else MST.
- MLD holds until dmem_ready=1, then -> WLD; WLD -> IF.
- MST holds until dmem_ready=1, then -> IF.
- HALT holds until reset.
REQ-012 A wait counter SHALL clear on entry to IF/MLD/MST and increment each stalled cycle in those states.
REQ-013 When the wait counter reaches WAIT_MAX with ready still 0, the FSM SHALL go to HALT and set bus_err.
REQ-014 PCWre SHALL be 1 exactly in the final cycle of each instruction:
- ID for j/jal/jr.
- EBR.
- MST with dmem_ready=1.
- WLD.
- WAL.
PCWre SHALL be 0 in all other cycles, and always 0 in HALT.
REQ-015 PCSrc:
- ID: j/jal -> 11, jr -> 10.
- EBR: 01 if (beq and zero) or (bne and !zero) or (bgtz and !zero and !sign).
- Otherwise 00, in all states.
REQ-016 RegWre SHALL be 1 in ID for jal (RegDst=00, WrRegDSrc=0), in WLD, and in WAL; WrRegDSrc SHALL be 1 in WLD/WAL.
REQ-017 RegDst SHALL be:
- 01 in WLD, and in WAL for addi/ori/slti.
- 10 in WAL for the other ALU ops.
- 00 otherwise.
REQ-018 ALU source and extend controls:
- ALUSrcA=1 only in EAL for sll.
- ALUSrcB=1 in EAL for addi/ori/slti, and in ELS.
- ExtSel=1 in EAL for addi/slti, and in ELS and EBR.
REQ-019 ALUOp in EAL:
- add/addi 000, sub 001, slt/slti 011, sll 100, or/ori 101, and 110.
- 000 in ELS, 001 in EBR, 000 elsewhere.
REQ-020 RD=0 and DBDataSrc=1 in MLD and WLD; WR=0 only in MST; both SHALL be 1 elsewhere.
REQ-021 All control outputs SHALL be combinational from state and opcode (plus flags/ready where stated); state, wait counter, flags and instr_count SHALL be registered.
REQ-022 instr_count SHALL increment by 1 on every cycle with PCWre=1, wrapping modulo 2^CNT_W.
REQ-023 halted SHALL be 1 whenever state=HALT.
REQ-024 With ready signals tied high, instruction latency SHALL be: j/jal/jr 2 cycles, beq/bne/bgtz 3, R/I ALU 4, sw 4, lw 5.

Reset
REQ-025 Reset=0 SHALL asynchronously force state=IF, wait counter=0, illegal=0, bus_err=0 and instr_count=0.
REQ-026 After reset, outputs SHALL follow IF decoding: all controls 0 except RD=1 and WR=1; InsMemRW and IRWre follow imem_ready.
REQ-027 Reset asserted mid-instruction (including in MST/MLD) SHALL abort that instruction with no PCWre, RegWre or WR=0 pulse afterward.

Verification
REQ-028 Ready high, add: state sequence 0,1,2,7,0 -> ALUOp=000 and RegDst=10/RegWre=1 in WAL, PCWre only in WAL, instr_count=1.
REQ-029 lw with dmem_ready low 3 cycles -> MLD held 4 cycles, RD=0 throughout; WLD has RegWre=1 and RegDst=01; total 8 cycles.
REQ-030 bgtz with zero=0 and sign=1 -> PCSrc=00 in EBR; repeat with sign=0 -> PCSrc=01; PCWre=1 in EBR both times.
REQ-031 imem_ready held 0, WAIT_MAX=7 -> HALT entered after 7 stalled cycles, bus_err=1, halted=1, PCWre stays 0.
REQ-032 Opcode 000011 -> ID goes to HALT, illegal=1; Reset low for 1 cycle -> state=0, flags=0, instr_count=0.
REQ-033 jal with CNT_W=4, count preloaded to 15 by 15 retirements -> ID has RegWre=1, PCSrc=11, RegDst=00; instr_count wraps to 0.

Source files
------------

// File: rtl/mc_control_unit_p.sv
// mc_control_unit_p: multicycle MIPS-style control unit (IF/ID/EX/MEM/WB FSM) with a memory-wait watchdog and retirement counter
// Ports: CLK/Reset (async active-low) clock and reset; opcode from IR; zero/sign ALU flags;
//   imem_ready/dmem_ready memory handshakes; PCWre..WR datapath strobes (RD/WR active-low);
//   PCSrc/RegDst/ALUOp datapath selects; state current FSM state; halted/illegal/bus_err sticky
//   status; instr_count retired-instruction counter.
module mc_control_unit_p #(
  parameter int OP_W = 6,
  parameter int CNT_W = 16,
  parameter int WAIT_MAX = 7
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             sign,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             PCWre,
  output logic             IRWre,
  output logic             InsMemRW,
  output logic             RegWre,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             DBDataSrc,
  output logic             WrRegDSrc,
  output logic             ExtSel,
  output logic             RD,
  output logic             WR,
  output logic [1:0]       PCSrc,
  output logic [1:0]       RegDst,
  output logic [2:0]       ALUOp,
  output logic [3:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EAL = 4'd2, S_EBR = 4'd3, S_ELS = 4'd4,
    S_MLD = 4'd5, S_MST = 4'd6, S_WAL = 4'd7, S_WLD = 4'd8, S_HALT = 4'd9
  } state_t;
  localparam int WW = $clog2(WAIT_MAX + 1);
  state_t st, nxt;
  logic [WW-1:0] wcnt;
  logic [5:0] op;
  logic hi_ok, i_add, i_sub, i_addi, i_or, i_and, i_ori, i_sll, i_slt, i_slti;
  logic i_sw, i_lw, i_beq, i_bne, i_bgtz, i_j, i_jr, i_jal, i_halt;
  logic alu, imm, br, ls, jmp, legal, taken, stall, tmo;
  logic [2:0] alu_code;
  assign op = opcode[5:0];
  // bits above the 6-bit opcode map must be zero for any opcode to decode as legal
  assign hi_ok  = (opcode >> 6) == '0;
  assign i_add  = hi_ok && op == 6'h00;
  assign i_sub  = hi_ok && op == 6'h01;
  assign i_addi = hi_ok && op == 6'h02;
  assign i_or   = hi_ok && op == 6'h10;
  assign i_and  = hi_ok && op == 6'h11;
  assign i_ori  = hi_ok && op == 6'h12;
  assign i_sll  = hi_ok && op == 6'h18;
  assign i_slt  = hi_ok && op == 6'h26;
  assign i_slti = hi_ok && op == 6'h27;
  assign i_sw   = hi_ok && op == 6'h30;
  assign i_lw   = hi_ok && op == 6'h31;
  assign i_beq  = hi_ok && op == 6'h34;
  assign i_bne  = hi_ok && op == 6'h35;
  assign i_bgtz = hi_ok && op == 6'h36;
  assign i_j    = hi_ok && op == 6'h38;
  assign i_jr   = hi_ok && op == 6'h39;
  assign i_jal  = hi_ok && op == 6'h3A;
  assign i_halt = hi_ok && op == 6'h3F;
  assign alu   = i_add | i_sub | i_addi | i_or | i_and | i_ori | i_sll | i_slt | i_slti;
  assign imm   = i_addi | i_ori | i_slti;
  assign br    = i_beq | i_bne | i_bgtz;
  assign ls    = i_sw | i_lw;
  assign jmp   = i_j | i_jal | i_jr;
  assign legal = alu | br | ls | jmp | i_halt;
  assign taken = (i_beq & zero) | (i_bne & ~zero) | (i_bgtz & ~zero & ~sign);
  assign alu_code = i_sub ? 3'b001 : (i_slt | i_slti) ? 3'b011 : i_sll ? 3'b100 :
                    (i_or | i_ori) ? 3'b101 : i_and ? 3'b110 : 3'b000;
  // stalled cycles count up; the WAIT_MAX-th consecutive stall times out
  assign stall = (st == S_IF && !imem_ready) || ((st == S_MLD || st == S_MST) && !dmem_ready);
  assign tmo   = stall && wcnt == WW'(WAIT_MAX - 1);
  always_comb begin
    nxt = S_IF;
    PCWre = 1'b0;
    IRWre = 1'b0;
    InsMemRW = 1'b0;
    RegWre = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 1'b0;
    DBDataSrc = 1'b0;
    WrRegDSrc = 1'b0;
    ExtSel = 1'b0;
    RD = 1'b1;
    WR = 1'b1;
    PCSrc = 2'b00;
    RegDst = 2'b00;
    ALUOp = 3'b000;
    case (st)
      S_IF: begin
        IRWre = imem_ready;
        InsMemRW = imem_ready;
        nxt = imem_ready ? S_ID : tmo ? S_HALT : S_IF;
      end
      S_ID: begin
        nxt = jmp ? S_IF : alu ? S_EAL : br ? S_EBR : ls ? S_ELS : S_HALT;
        PCWre = jmp;
        PCSrc = (i_j | i_jal) ? 2'b11 : i_jr ? 2'b10 : 2'b00;
        RegWre = i_jal;
      end
      S_EAL: begin
        nxt = S_WAL;
        ALUSrcA = i_sll;
        ALUSrcB = imm;
        ExtSel = i_addi | i_slti;
        ALUOp = alu_code;
      end
      S_EBR: begin
        PCWre = 1'b1;
        PCSrc = taken ? 2'b01 : 2'b00;
        ExtSel = 1'b1;
        ALUOp = 3'b001;
      end
      S_ELS: begin
        nxt = i_lw ? S_MLD : S_MST;
        ALUSrcB = 1'b1;
        ExtSel = 1'b1;
      end
      S_MLD: begin
        nxt = dmem_ready ? S_WLD : tmo ? S_HALT : S_MLD;
        RD = 1'b0;
        DBDataSrc = 1'b1;
      end
      S_MST: begin
        nxt = dmem_ready ? S_IF : tmo ? S_HALT : S_MST;
        WR = 1'b0;
        PCWre = dmem_ready;
      end
      S_WAL: begin
        PCWre = 1'b1;
        RegWre = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst = imm ? 2'b01 : 2'b10;
      end
      S_WLD: begin
        PCWre = 1'b1;
        RegWre = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst = 2'b01;
        RD = 1'b0;
        DBDataSrc = 1'b1;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IF;
    endcase
  end
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      st <= S_IF;
      wcnt <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
      instr_count <= '0;
    end else begin
      st <= nxt;
      wcnt <= stall ? wcnt + 1'b1 : '0;
      illegal <= illegal | (st == S_ID && !legal);
      bus_err <= bus_err | tmo;
      instr_count <= instr_count + CNT_W'(PCWre);
    end
  end
  assign state = st;
  assign halted = st == S_HALT;
endmodule
